// File: rtl/fmul_mant_norm.sv
// Binary32 multiplier back end: shift-add significand multiply, normalise, round, pack.
// Optional round-to-nearest-even under `FMUL_ROUND_EN (truncation otherwise).
module fmul_mant_norm #(
  parameter int MANT_W  = 23,
  parameter int EXP_W   = 10,
  parameter int EXP_MAX = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sign_a,
  input  logic              sign_b,
  input  logic [MANT_W-1:0] frac_a,
  input  logic [MANT_W-1:0] frac_b,
  input  logic              a_zero,
  input  logic              b_zero,
  input  logic [EXP_W-1:0]  exp_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       result,
  output logic              ovf,
  output logic              unf
);

  localparam int SIG_W = MANT_W + 1;
  localparam int PW    = 2 * SIG_W;
  localparam int CNT_W = $clog2(SIG_W);
  localparam int EF_W  = 31 - MANT_W;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] MUL  = 3'd1;
  localparam logic [2:0] NORM = 3'd2;
  localparam logic [2:0] RND  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SIG_W - 1);
  localparam logic signed [EXP_W-1:0] EMAX = EXP_W'(EXP_MAX);

  logic [2:0]               state;
  logic [CNT_W-1:0]         cnt;
  logic [SIG_W-1:0]         ma;
  logic [SIG_W-1:0]         mb;
  logic [PW-1:0]            acc;
  logic signed [EXP_W-1:0]  exp_r;
  logic                     sign_r;
  logic                     zero_r;
  logic [MANT_W:0]          sig_r;
  logic                     sticky_r;

  logic                     round_up;
  logic [MANT_W:0]          rsum;
  logic                     carry;
  logic [MANT_W-1:0]        frac_f;
  logic signed [EXP_W-1:0]  exp_f;
  logic [PW-1:0]            pp;

  assign in_ready = (state == IDLE);
  assign pp = mb[cnt] ? ({{SIG_W{1'b0}}, ma} << cnt) : '0;

`ifdef FMUL_ROUND_EN
  assign round_up = sig_r[0] & (sticky_r | sig_r[1]);
`else
  logic unused_rnd;
  assign unused_rnd = sig_r[0] ^ sticky_r;
  assign round_up   = 1'b0;
`endif

  // sig_r holds frac plus guard in bit 0; the hidden bit is implied
  assign rsum   = {1'b0, sig_r[MANT_W:1]} + (MANT_W+1)'(round_up);
  assign carry  = rsum[MANT_W];
  assign frac_f = carry ? '0 : rsum[MANT_W-1:0];
  assign exp_f  = exp_r + EXP_W'(carry);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      ma        <= '0;
      mb        <= '0;
      acc       <= '0;
      exp_r     <= '0;
      sign_r    <= 1'b0;
      zero_r    <= 1'b0;
      sig_r     <= '0;
      sticky_r  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            ma     <= {1'b1, frac_a};
            mb     <= {1'b1, frac_b};
            exp_r  <= exp_in;
            sign_r <= sign_a ^ sign_b;
            zero_r <= a_zero | b_zero;
            cnt    <= '0;
            acc    <= '0;
            state  <= (a_zero | b_zero) ? RND : MUL;
          end
        end
        MUL: begin
          acc <= acc + pp;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= NORM;
        end
        NORM: begin
          if (acc[PW-1]) begin
            sig_r    <= acc[PW-2 -: MANT_W+1];
            sticky_r <= |acc[PW-SIG_W-2:0];
            exp_r    <= exp_r + 1'b1;
          end else begin
            sig_r    <= acc[PW-3 -: MANT_W+1];
            sticky_r <= |acc[PW-SIG_W-3:0];
          end
          state <= RND;
        end
        RND: begin
          ovf <= 1'b0;
          unf <= 1'b0;
          if (zero_r) begin
            result <= {sign_r, 31'b0};
          end else if (exp_f >= EMAX) begin
            result <= {sign_r, {EF_W{1'b1}}, {MANT_W{1'b0}}};
            ovf    <= 1'b1;
          end else if (exp_f[EXP_W-1] || exp_f == '0) begin
            result <= {sign_r, 31'b0};
            unf    <= 1'b1;
          end else begin
            result <= {sign_r, exp_f[EF_W-1:0], frac_f};
          end
          state <= DONE;
        end
        DONE: begin
          // result settles for one cycle before being presented
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fmul_mant_norm.sv
// Directed bench for fmul_mant_norm: latency, packing, rounding, range and handshake checks.
// Expected rounding result follows `FMUL_ROUND_EN.
module tb_fmul_mant_norm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        sign_a = 1'b0;
  logic        sign_b = 1'b0;
  logic [22:0] frac_a = '0;
  logic [22:0] frac_b = '0;
  logic        a_zero = 1'b0;
  logic        b_zero = 1'b0;
  logic [9:0]  exp_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        ovf;
  logic        unf;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fmul_mant_norm dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .sign_a(sign_a), .sign_b(sign_b),
    .frac_a(frac_a), .frac_b(frac_b),
    .a_zero(a_zero), .b_zero(b_zero),
    .exp_in(exp_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .ovf(ovf), .unf(unf)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic run_op(input string tag,
                        input logic sa, input logic sb,
                        input logic [22:0] fa, input logic [22:0] fb,
                        input logic az, input logic bz,
                        input logic [9:0] e,
                        input logic [31:0] x_res,
                        input logic x_ovf, input logic x_unf,
                        input int x_lat, input int hold);
    int lat;
    int w;
    w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    chk({tag, " ready"}, 64'(in_ready), 64'd1);
    sign_a = sa; sign_b = sb;
    frac_a = fa; frac_b = fb;
    a_zero = az; b_zero = bz;
    exp_in = e;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(x_lat));
    chk({tag, " result"}, 64'(result), 64'(x_res));
    chk({tag, " ovf"}, 64'(ovf), 64'(x_ovf));
    chk({tag, " unf"}, 64'(unf), 64'(x_unf));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, " hold"}, {30'b0, out_valid, in_ready, result},
          {30'b0, 1'b1, 1'b0, x_res});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " drop"}, {62'b0, out_valid, in_ready}, 64'b01);
  endtask

  initial begin
    logic [31:0] rnd_exp;
    logic        seen;
`ifdef FMUL_ROUND_EN
    rnd_exp = 32'h3FC00002;
`else
    rnd_exp = 32'h3FC00001;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst result", 64'(result), 64'd0);
    chk("rst ovf", 64'(ovf), 64'd0);
    chk("rst unf", 64'(unf), 64'd0);
    rst_n = 1'b1;

    run_op("2x3", 0, 0, 23'h0, 23'h400000, 0, 0, 10'd129,
           32'h40C00000, 0, 0, 27, 0);
    run_op("1.5x-1.5", 0, 1, 23'h400000, 23'h400000, 0, 0, 10'd127,
           32'hC0100000, 0, 0, 27, 0);
    run_op("tie", 0, 0, 23'h000001, 23'h400000, 0, 0, 10'd127,
           rnd_exp, 0, 0, 27, 0);
    run_op("max*max", 0, 0, 23'h7FFFFF, 23'h7FFFFF, 0, 0, 10'd127,
           32'h407FFFFE, 0, 0, 27, 0);
    run_op("ovf300", 0, 0, 23'h0, 23'h0, 0, 0, 10'd300,
           32'h7F800000, 1, 0, 27, 0);
    run_op("ovf_norm", 1, 0, 23'h400000, 23'h400000, 0, 0, 10'd254,
           32'hFF800000, 1, 0, 27, 0);
    run_op("unf-5", 0, 0, 23'h0, 23'h0, 0, 0, 10'h3FB,
           32'h00000000, 0, 1, 27, 0);
    run_op("unf0", 1, 1, 23'h0, 23'h0, 0, 0, 10'd0,
           32'h00000000, 0, 1, 27, 0);
    run_op("min_norm", 0, 0, 23'h0, 23'h0, 0, 0, 10'd1,
           32'h00800000, 0, 0, 27, 0);
    run_op("zero", 0, 1, 23'h123456, 23'h0, 1, 0, 10'd300,
           32'h80000000, 0, 0, 2, 0);
    run_op("backpr", 0, 0, 23'h0, 23'h400000, 0, 0, 10'd129,
           32'h40C00000, 0, 0, 27, 10);

    sign_a = 0; sign_b = 0;
    frac_a = 23'h0; frac_b = 23'h400000;
    a_zero = 0; b_zero = 0;
    exp_in = 10'd129;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst in_ready", 64'(in_ready), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("midrst no_out", 64'(seen), 64'd0);
    run_op("after_rst", 0, 0, 23'h0, 23'h400000, 0, 0, 10'd129,
           32'h40C00000, 0, 0, 27, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
